// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the soc_system_pio_in input port: register
// offsets, edge-capture encodings and the per-bit edge-detect helper.
package soc_system_pio_pkg;

    // Avalon word offsets
    localparam logic [1:0] PIO_REG_DATA    = 2'd0;
    localparam logic [1:0] PIO_REG_DIR     = 2'd1;
    localparam logic [1:0] PIO_REG_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_REG_EDGECAP = 2'd3;

    // EDGE_TYPE encodings
    localparam int PIO_EDGE_RISING  = 0;
    localparam int PIO_EDGE_FALLING = 1;
    localparam int PIO_EDGE_ANY     = 2;

    // Per-bit edge detect on the filtered level and its delayed copy.
    // Unknown encodings fall back to rising-edge detection.
    function automatic logic [31:0] pio_edge_detect(
        input logic [31:0] level,
        input logic [31:0] level_d,
        input int          edge_type
    );
        logic [31:0] result;
        case (edge_type)
            PIO_EDGE_RISING:  result = level & ~level_d;
            PIO_EDGE_FALLING: result = ~level & level_d;
            PIO_EDGE_ANY:     result = level ^ level_d;
            default:          result = level & ~level_d;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/soc_system_pio_in_filter.sv
// Single-bit input conditioning for soc_system_pio_in: 2-FF synchronizer
// followed by either a debounce counter (SOC_SYSTEM_PIO_IN_DEBOUNCE_EN
// defined) or a plain register. The filtered level is held until the
// parent arms the port, at which point it loads the synchronized value
// directly so that no artificial edge is seen at start-up.
module soc_system_pio_filter #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arm_load,
    input  logic armed,
    input  logic in_bit,
    output logic sync,
    output logic level
);

    logic sync1_r;
    logic sync2_r;
    logic level_r;

    // Two-flop synchronizer for the asynchronous input bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= in_bit;
            sync2_r <= sync1_r;
        end
    end

`ifdef SOC_SYSTEM_PIO_IN_DEBOUNCE_EN
    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;

    // Debounce: the counter runs only while sync2 disagrees with level;
    // any return to agreement restarts it, so short pulses never reach level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (arm_load) begin
            level_r <= sync2_r;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (!armed || (sync2_r == level_r)) begin
            level_r <= level_r;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            level_r <= sync2_r;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            level_r <= level_r;
            cnt_r   <= cnt_r + CNT_W'(1);
        end
    end
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Pass-through: level is sync2 registered once the port is armed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_r <= 1'b0;
        end else if (arm_load || armed) begin
            level_r <= sync2_r;
        end else begin
            level_r <= level_r;
        end
    end
`endif

    assign sync  = sync2_r;
    assign level = level_r;

endmodule

// File: rtl/soc_system_pio_in.sv
// Avalon-MM input PIO: synchronized/filtered input level at offset 0,
// interrupt mask at offset 2, write-1-to-clear edge capture at offset 3,
// and a level irq for unmasked captured edges.
// Optional debounce filter: define SOC_SYSTEM_PIO_IN_DEBOUNCE_EN.
module soc_system_pio_in #(
    parameter int WIDTH           = 3,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    import soc_system_pio_pkg::*;

    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] level_s;
    logic [WIDTH-1:0] level_d_r;
    logic [WIDTH-1:0] irqmask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] capture_s;
    logic [WIDTH-1:0] clear_s;
    logic [WIDTH-1:0] wdata_s;
    logic [1:0]       arm_cnt_r;
    logic             armed_r;
    logic             arm_load_s;
    logic             wr_en_s;
    logic             wr_irqmask_s;
    logic             wr_edgecap_s;
    logic             unused_writedata_s;

    // One synchronizer/filter per input bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        soc_system_pio_filter #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_filter (
            .clk      (clk),
            .reset_n  (reset_n),
            .arm_load (arm_load_s),
            .armed    (armed_r),
            .in_bit   (in_port[i]),
            .sync     (sync_s[i]),
            .level    (level_s[i])
        );
    end

    // Arming: count out the sync chain after reset, then load level once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_r <= 2'd0;
            armed_r   <= 1'b0;
        end else begin
            if (arm_cnt_r != 2'd3) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
            if (arm_load_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Arm pulse is a single cycle: count saturated but not yet armed
    always_comb begin
        arm_load_s = (arm_cnt_r == 2'd3) && !armed_r;
    end

    // Delayed copy of the filtered level; aligned with level at arm time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_d_r <= {WIDTH{1'b0}};
        end else if (arm_load_s) begin
            level_d_r <= sync_s;
        end else begin
            level_d_r <= level_s;
        end
    end

    // Bus write decode and edge/clear vectors
    always_comb begin
        wr_en_s            = chipselect && !write_n;
        wr_irqmask_s       = wr_en_s && (address == PIO_REG_IRQMASK);
        wr_edgecap_s       = wr_en_s && (address == PIO_REG_EDGECAP);
        wdata_s            = writedata[WIDTH-1:0];
        unused_writedata_s = ^writedata;
        edge_s             = WIDTH'(pio_edge_detect(32'(level_s), 32'(level_d_r), EDGE_TYPE));
        if (armed_r) begin
            capture_s = edge_s;
        end else begin
            capture_s = {WIDTH{1'b0}};
        end
        if (wr_edgecap_s) begin
            clear_s = wdata_s;
        end else begin
            clear_s = {WIDTH{1'b0}};
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_r <= {WIDTH{1'b0}};
        end else if (wr_irqmask_s) begin
            irqmask_r <= wdata_s;
        end else begin
            irqmask_r <= irqmask_r;
        end
    end

    // Edge capture: write-1 clears, a same-cycle edge on that bit wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap_r <= {WIDTH{1'b0}};
        end else begin
            edgecap_r <= (edgecap_r & ~clear_s) | capture_s;
        end
    end

    // Zero-wait-state read mux, independent of chipselect
    always_comb begin
        case (address)
            PIO_REG_DATA:    readdata = 32'(level_s);
            PIO_REG_DIR:     readdata = 32'd0;
            PIO_REG_IRQMASK: readdata = 32'(irqmask_r);
            PIO_REG_EDGECAP: readdata = 32'(edgecap_r);
            default:         readdata = 32'd0;
        endcase
    end

    // Level interrupt from unmasked captured edges
    always_comb begin
        irq = |(edgecap_r & irqmask_r);
    end

endmodule
